// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcodes, ALU-op encoding,
// the packed control bundle and the opcode decoder.
package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    typedef struct packed {
        logic   branch_eq;
        logic   branch_ne;
        logic   jump;
        logic   alusrc;
        logic   memread;
        logic   memwrite;
        logic   regwrite;
        logic   regdst;
        logic   memtoreg;
        aluop_t aluop;
    } id_ctrl_t;

    function automatic id_ctrl_t decode_op(input logic [5:0] op);
        id_ctrl_t c;
        c = '0;
        unique case (op)
            OP_RTYPE: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
                c.aluop    = ALUOP_FUNCT;
            end
            OP_LW: begin
                c.alusrc   = 1'b1;
                c.memread  = 1'b1;
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            OP_SW: begin
                c.alusrc   = 1'b1;
                c.memwrite = 1'b1;
            end
            OP_BEQ: begin
                c.branch_eq = 1'b1;
                c.aluop     = ALUOP_SUB;
            end
            OP_BNE: begin
                c.branch_ne = 1'b1;
                c.aluop     = ALUOP_SUB;
            end
            OP_J: c.jump = 1'b1;
            OP_ADDI: begin
                c.alusrc   = 1'b1;
                c.regwrite = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Opcodes whose rt field is a source operand (not a destination).
    function automatic logic reads_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/id_regfile.sv
// 2-read 1-write register file, r0 hardwired to zero, write-through bypass.
// Ports: clk, rst (async clear), ra_a/ra_b read indices, rd_a/rd_b read
// data, we/wa/wd write port (written on rising clk).
module id_regfile #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ra_a,
    input  logic [REG_AW-1:0] ra_b,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd
);

    localparam int NREG = 2 ** REG_AW;

    logic [DATA_W-1:0] mem [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (we && wa != '0) begin
            mem[wa] <= wd;
        end
    end

    // Same-cycle write data wins so WB results reach ID without a stall.
    always_comb begin
        rd_a = mem[ra_a];
        if (ra_a == '0)
            rd_a = '0;
        else if (we && wa == ra_a)
            rd_a = wd;
    end

    always_comb begin
        rd_b = mem[ra_b];
        if (ra_b == '0)
            rd_b = '0;
        else if (we && wa == ra_b)
            rd_b = wd;
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage with ID/EX register, load-use bubble, flush and
// EX back-pressure. Ports: clk/rst; IF/ID side id_valid_i, instr_i, npc_i,
// stall_o; flush_i; ex_ready_i; WB port wb_*; ID/EX outputs ex_valid_o,
// control bits, aluop_o, npc_o, rs/rt data, imm_o, rs/rt/rd indices.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid_i,
    input  logic [31:0]       instr_i,
    input  logic [DATA_W-1:0] npc_i,
    output logic              stall_o,
    input  logic              flush_i,
    input  logic              ex_ready_i,
    input  logic              wb_we_i,
    input  logic [REG_AW-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic              ex_valid_o,
    output logic              branch_eq_o,
    output logic              branch_ne_o,
    output logic              jump_o,
    output logic              alusrc_o,
    output logic              memread_o,
    output logic              memwrite_o,
    output logic              regwrite_o,
    output logic              regdst_o,
    output logic              memtoreg_o,
    output logic [1:0]        aluop_o,
    output logic [DATA_W-1:0] npc_o,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [REG_AW-1:0] rs_o,
    output logic [REG_AW-1:0] rt_o,
    output logic [REG_AW-1:0] rd_o
);

    logic [5:0]        op;
    logic [REG_AW-1:0] rs, rt, rd;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] rs_rd, rt_rd;
    id_ctrl_t          dec_ctrl;

    assign op       = instr_i[31:26];
    assign rs       = instr_i[21 +: REG_AW];
    assign rt       = instr_i[16 +: REG_AW];
    assign rd       = instr_i[11 +: REG_AW];
    assign imm      = {{(DATA_W-16){instr_i[15]}}, instr_i[15:0]};
    assign dec_ctrl = decode_op(op);

    id_regfile #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_rf (
        .clk  (clk),
        .rst  (rst),
        .ra_a (rs),
        .ra_b (rt),
        .rd_a (rs_rd),
        .rd_b (rt_rd),
        .we   (wb_we_i),
        .wa   (wb_addr_i),
        .wd   (wb_data_i)
    );

    logic              ex_valid_q;
    id_ctrl_t          ctrl_q;
    logic [DATA_W-1:0] npc_q, rs_data_q, rt_data_q, imm_q;
    logic [REG_AW-1:0] rs_q, rt_q, rd_q;

    logic hz, hold;

    // A load in ID/EX whose target is consumed by the ID instruction.
    assign hz = ex_valid_q && ctrl_q.memread && (rt_q != '0) && id_valid_i &&
                ((rt_q == rs) || ((rt_q == rt) && reads_rt(op)));

    // Bubbles never back-pressure: only a real instruction waits for EX.
    assign hold    = ex_valid_q && !ex_ready_i;
    assign stall_o = !flush_i && (hz || hold);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ctrl_q     <= '0;
            npc_q      <= '0;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
        end else if (flush_i || (!hold && hz)) begin
            ex_valid_q <= 1'b0;
            ctrl_q     <= '0;
        end else if (!hold) begin
            ex_valid_q <= id_valid_i;
            ctrl_q     <= id_valid_i ? dec_ctrl : '0;
            npc_q      <= npc_i;
            rs_data_q  <= rs_rd;
            rt_data_q  <= rt_rd;
            imm_q      <= imm;
            rs_q       <= rs;
            rt_q       <= rt;
            rd_q       <= rd;
        end
    end

    assign ex_valid_o  = ex_valid_q;
    assign branch_eq_o = ctrl_q.branch_eq;
    assign branch_ne_o = ctrl_q.branch_ne;
    assign jump_o      = ctrl_q.jump;
    assign alusrc_o    = ctrl_q.alusrc;
    assign memread_o   = ctrl_q.memread;
    assign memwrite_o  = ctrl_q.memwrite;
    assign regwrite_o  = ctrl_q.regwrite;
    assign regdst_o    = ctrl_q.regdst;
    assign memtoreg_o  = ctrl_q.memtoreg;
    assign aluop_o     = ctrl_q.aluop;
    assign npc_o       = npc_q;
    assign rs_data_o   = rs_data_q;
    assign rt_data_o   = rt_data_q;
    assign imm_o       = imm_q;
    assign rs_o        = rs_q;
    assign rt_o        = rt_q;
    assign rd_o        = rd_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed scenarios plus a random
// run against a cycle-level reference model of the decode stage.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid_i;
    logic [31:0] instr_i, npc_i;
    logic        stall_o, flush_i, ex_ready_i;
    logic        wb_we_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic        ex_valid_o;
    logic        branch_eq_o, branch_ne_o, jump_o, alusrc_o, memread_o;
    logic        memwrite_o, regwrite_o, regdst_o, memtoreg_o;
    logic [1:0]  aluop_o;
    logic [31:0] npc_o, rs_data_o, rt_data_o, imm_o;
    logic [4:0]  rs_o, rt_o, rd_o;

    id_stage_pipe #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .instr_i(instr_i),
        .npc_i(npc_i), .stall_o(stall_o), .flush_i(flush_i),
        .ex_ready_i(ex_ready_i), .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i),
        .wb_data_i(wb_data_i), .ex_valid_o(ex_valid_o),
        .branch_eq_o(branch_eq_o), .branch_ne_o(branch_ne_o),
        .jump_o(jump_o), .alusrc_o(alusrc_o), .memread_o(memread_o),
        .memwrite_o(memwrite_o), .regwrite_o(regwrite_o),
        .regdst_o(regdst_o), .memtoreg_o(memtoreg_o), .aluop_o(aluop_o),
        .npc_o(npc_o), .rs_data_o(rs_data_o), .rt_data_o(rt_data_o),
        .imm_o(imm_o), .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Control vector: beq bne j alusrc memread memwrite regwrite regdst
    // memtoreg aluop[1:0]
    logic [10:0] dut_ctrl;
    assign dut_ctrl = {branch_eq_o, branch_ne_o, jump_o, alusrc_o, memread_o,
                       memwrite_o, regwrite_o, regdst_o, memtoreg_o, aluop_o};

    localparam logic [10:0] C_R    = 11'b00000011010;
    localparam logic [10:0] C_LW   = 11'b00011010100;
    localparam logic [10:0] C_SW   = 11'b00010100000;
    localparam logic [10:0] C_BEQ  = 11'b10000000001;
    localparam logic [10:0] C_BNE  = 11'b01000000001;
    localparam logic [10:0] C_J    = 11'b00100000000;
    localparam logic [10:0] C_ADDI = 11'b00010010000;

    // Reference model state
    logic [31:0] mreg [32];
    logic        e_valid;
    logic [10:0] e_ctrl;
    logic [31:0] e_npc, e_rsd, e_rtd, e_imm;
    logic [4:0]  e_rs, e_rt, e_rd;
    logic        exp_stall;

    function automatic logic [10:0] ref_ctrl(input logic [5:0] op);
        case (op)
            6'h00:   return C_R;
            6'h23:   return C_LW;
            6'h2B:   return C_SW;
            6'h04:   return C_BEQ;
            6'h05:   return C_BNE;
            6'h02:   return C_J;
            6'h08:   return C_ADDI;
            default: return 11'b0;
        endcase
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op,
        input logic [4:0] s, input logic [4:0] t, input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] s,
        input logic [4:0] t, input logic [4:0] d);
        return {6'h00, s, t, d, 11'h020};
    endfunction

    function automatic logic [31:0] rd_model(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (wb_we_i && wb_addr_i == idx) return wb_data_i;
        return mreg[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        e_valid = 0; e_ctrl = '0; e_npc = '0; e_rsd = '0; e_rtd = '0;
        e_imm = '0; e_rs = '0; e_rt = '0; e_rd = '0;
    endtask

    task automatic calc_stall(output logic hz_out);
        logic [5:0] op;
        logic [4:0] s, t;
        logic       uses_t;
        op = instr_i[31:26]; s = instr_i[25:21]; t = instr_i[20:16];
        uses_t = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04) ||
                 (op == 6'h05);
        hz_out = e_valid && e_ctrl[6] && e_rt != 0 && id_valid_i &&
                 (e_rt == s || (e_rt == t && uses_t));
        exp_stall = !flush_i && (hz_out || (e_valid && !ex_ready_i));
    endtask

    // Advance one clock edge and the model alongside it.
    task automatic cycle();
        logic        hz_m;
        logic [31:0] a, b;
        calc_stall(hz_m);
        a = rd_model(instr_i[25:21]);
        b = rd_model(instr_i[20:16]);
        @(posedge clk);
        if (flush_i) begin
            e_valid = 0; e_ctrl = '0;
        end else if (e_valid && !ex_ready_i) begin
        end else if (hz_m) begin
            e_valid = 0; e_ctrl = '0;
        end else begin
            e_valid = id_valid_i;
            e_ctrl  = id_valid_i ? ref_ctrl(instr_i[31:26]) : 11'b0;
            e_npc = npc_i; e_rsd = a; e_rtd = b;
            e_imm = {{16{instr_i[15]}}, instr_i[15:0]};
            e_rs = instr_i[25:21]; e_rt = instr_i[20:16];
            e_rd = instr_i[15:11];
        end
        if (wb_we_i && wb_addr_i != 0) mreg[wb_addr_i] = wb_data_i;
        #1;
    endtask

    task automatic idle_inputs();
        id_valid_i = 0; instr_i = '0; npc_i = '0; flush_i = 0;
        ex_ready_i = 1; wb_we_i = 0; wb_addr_i = '0; wb_data_i = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
        id_valid_i = 1; instr_i = ins; npc_i = pc;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        #2;
        n_cmp++;
        if (ex_valid_o !== 1'b0 || dut_ctrl !== 11'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: valid=%b ctrl=%b want 0/0",
                     ex_valid_o, dut_ctrl);
        end
        n_cmp++;
        if ({npc_o, rs_data_o, rt_data_o, imm_o, rs_o, rt_o, rd_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: npc=%h rs=%h rt=%h imm=%h want 0",
                     npc_o, rs_data_o, rt_data_o, imm_o);
        end
        n_cmp++;
        if (stall_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_stall: got %b want 0", stall_o);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic test_lw_decode();
        apply_reset();
        drive(itype(6'h23, 5'd1, 5'd2, 16'h0004), 32'h104);
        cycle();
        n_cmp++;
        if (ex_valid_o !== 1'b1 || dut_ctrl !== C_LW) begin
            n_bad++;
            $display("FAIL lw_ctrl: valid=%b ctrl=%b want 1/%b",
                     ex_valid_o, dut_ctrl, C_LW);
        end
        n_cmp++;
        if (imm_o !== 32'h4 || rt_o !== 5'd2 || npc_o !== 32'h104) begin
            n_bad++;
            $display("FAIL lw_fields: imm=%h rt=%0d npc=%h want 4/2/104",
                     imm_o, rt_o, npc_o);
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        drive(itype(6'h23, 5'd1, 5'd2, 16'h0000), 32'h200);
        cycle();
        drive(rtype(5'd2, 5'd4, 5'd3), 32'h204);
        #1;
        n_cmp++;
        if (stall_o !== 1'b1) begin
            n_bad++;
            $display("FAIL lu_stall: got %b want 1", stall_o);
        end
        cycle();
        n_cmp++;
        if (ex_valid_o !== 1'b0 || dut_ctrl !== 11'b0 || stall_o !== 1'b0) begin
            n_bad++;
            $display("FAIL lu_bubble: valid=%b ctrl=%b stall=%b want 0/0/0",
                     ex_valid_o, dut_ctrl, stall_o);
        end
        cycle();
        n_cmp++;
        if (ex_valid_o !== 1'b1 || rs_o !== 5'd2 || dut_ctrl !== C_R) begin
            n_bad++;
            $display("FAIL lu_issue: valid=%b rs=%0d ctrl=%b want 1/2/%b",
                     ex_valid_o, rs_o, dut_ctrl, C_R);
        end
    endtask

    task automatic test_bypass();
        apply_reset();
        wb_we_i = 1; wb_addr_i = 5'd5; wb_data_i = 32'hDEADBEEF;
        drive(rtype(5'd5, 5'd0, 5'd6), 32'h300);
        cycle();
        n_cmp++;
        if (rs_data_o !== 32'hDEADBEEF || rt_data_o !== 32'h0) begin
            n_bad++;
            $display("FAIL bypass: rs=%h rt=%h want deadbeef/0",
                     rs_data_o, rt_data_o);
        end
        wb_addr_i = 5'd0; wb_data_i = 32'h12345678;
        drive(rtype(5'd0, 5'd5, 5'd1), 32'h304);
        cycle();
        n_cmp++;
        if (rs_data_o !== 32'h0 || rt_data_o !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL r0_array: rs=%h rt=%h want 0/deadbeef",
                     rs_data_o, rt_data_o);
        end
        wb_we_i = 0;
    endtask

    task automatic test_backpressure();
        logic [31:0] snap_npc;
        logic [10:0] snap_ctrl;
        logic [4:0]  snap_rd;
        apply_reset();
        drive(rtype(5'd1, 5'd2, 5'd3), 32'h400);
        cycle();
        snap_npc = npc_o; snap_ctrl = dut_ctrl; snap_rd = rd_o;
        ex_ready_i = 0;
        drive(itype(6'h08, 5'd1, 5'd9, 16'h0007), 32'h404);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (stall_o !== 1'b1) begin
                n_bad++;
                $display("FAIL bp_stall[%0d]: got %b want 1", i, stall_o);
            end
            cycle();
            n_cmp++;
            if (ex_valid_o !== 1'b1 || npc_o !== snap_npc ||
                dut_ctrl !== snap_ctrl || rd_o !== snap_rd) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: npc=%h ctrl=%b rd=%0d want %h/%b/%0d",
                         i, npc_o, dut_ctrl, rd_o, snap_npc, C_R, 3);
            end
        end
        ex_ready_i = 1;
        #1;
        n_cmp++;
        if (stall_o !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_release_stall: got %b want 0", stall_o);
        end
        cycle();
        n_cmp++;
        if (rt_o !== 5'd9 || dut_ctrl !== C_ADDI || npc_o !== 32'h404) begin
            n_bad++;
            $display("FAIL bp_next: rt=%0d ctrl=%b npc=%h want 9/%b/404",
                     rt_o, dut_ctrl, npc_o, C_ADDI);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        drive(itype(6'h23, 5'd1, 5'd7, 16'h0000), 32'h500);
        cycle();
        ex_ready_i = 0;
        drive(rtype(5'd7, 5'd7, 5'd8), 32'h504);
        flush_i = 1;
        #1;
        n_cmp++;
        if (stall_o !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_stall: got %b want 0", stall_o);
        end
        cycle();
        n_cmp++;
        if (ex_valid_o !== 1'b0 || dut_ctrl !== 11'b0) begin
            n_bad++;
            $display("FAIL flush_kill: valid=%b ctrl=%b want 0/0",
                     ex_valid_o, dut_ctrl);
        end
        flush_i = 0; ex_ready_i = 1;
    endtask

    task automatic test_nop_imm();
        apply_reset();
        drive(itype(6'h3F, 5'd1, 5'd2, 16'h1234), 32'h600);
        cycle();
        n_cmp++;
        if (ex_valid_o !== 1'b1 || dut_ctrl !== 11'b0) begin
            n_bad++;
            $display("FAIL nop_op3f: valid=%b ctrl=%b want 1/0",
                     ex_valid_o, dut_ctrl);
        end
        drive(itype(6'h08, 5'd1, 5'd4, 16'h8000), 32'h604);
        cycle();
        n_cmp++;
        if (imm_o !== 32'hFFFF8000 || dut_ctrl !== C_ADDI) begin
            n_bad++;
            $display("FAIL addi_sext: imm=%h ctrl=%b want ffff8000/%b",
                     imm_o, dut_ctrl, C_ADDI);
        end
    endtask

    task automatic test_reset_mid_stall();
        apply_reset();
        drive(itype(6'h23, 5'd1, 5'd2, 16'h0000), 32'h700);
        cycle();
        drive(rtype(5'd2, 5'd3, 5'd4), 32'h704);
        #1;
        rst = 1;
        #1;
        n_cmp++;
        if (stall_o !== 1'b0 || ex_valid_o !== 1'b0 || dut_ctrl !== 11'b0) begin
            n_bad++;
            $display("FAIL rst_mid: stall=%b valid=%b ctrl=%b want 0/0/0",
                     stall_o, ex_valid_o, dut_ctrl);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        cycle();
        n_cmp++;
        if (ex_valid_o !== 1'b1 || rs_o !== 5'd2 || dut_ctrl !== C_R) begin
            n_bad++;
            $display("FAIL rst_restart: valid=%b rs=%0d ctrl=%b want 1/2/%b",
                     ex_valid_o, rs_o, dut_ctrl, C_R);
        end
    endtask

    task automatic test_random();
        logic [5:0] pool [9];
        logic [5:0] op;
        logic       hz_dummy;
        pool = '{6'h00, 6'h23, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h3F};
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            op = pool[$urandom_range(0, 8)];
            id_valid_i = ($urandom_range(0, 99) < 85);
            instr_i = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 7)), 11'($urandom)};
            npc_i = $urandom;
            ex_ready_i = ($urandom_range(0, 99) < 75);
            flush_i = ($urandom_range(0, 99) < 6);
            wb_we_i = $urandom_range(0, 1);
            wb_addr_i = 5'($urandom_range(0, 7));
            wb_data_i = $urandom;
            #1;
            calc_stall(hz_dummy);
            n_cmp++;
            if (stall_o !== exp_stall) begin
                n_bad++;
                $display("FAIL rnd_stall[%0d]: got %b want %b",
                         n, stall_o, exp_stall);
            end
            cycle();
            n_cmp++;
            if (ex_valid_o !== e_valid || dut_ctrl !== e_ctrl) begin
                n_bad++;
                $display("FAIL rnd_ctrl[%0d]: valid=%b ctrl=%b want %b/%b",
                         n, ex_valid_o, dut_ctrl, e_valid, e_ctrl);
            end
            n_cmp++;
            if (rs_data_o !== e_rsd || rt_data_o !== e_rtd) begin
                n_bad++;
                $display("FAIL rnd_data[%0d]: rs=%h rt=%h want %h/%h",
                         n, rs_data_o, rt_data_o, e_rsd, e_rtd);
            end
            n_cmp++;
            if (npc_o !== e_npc || imm_o !== e_imm || rs_o !== e_rs ||
                rt_o !== e_rt || rd_o !== e_rd) begin
                n_bad++;
                $display("FAIL rnd_fields[%0d]: npc=%h imm=%h idx=%0d/%0d/%0d want %h/%h %0d/%0d/%0d",
                         n, npc_o, imm_o, rs_o, rt_o, rd_o,
                         e_npc, e_imm, e_rs, e_rt, e_rd);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_lw_decode();
        test_load_use();
        test_bypass();
        test_backpressure();
        test_flush();
        test_nop_imm();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
